// File: rtl/pp_param_loader.sv
// pp_param_loader
//
// Loads per-output-channel bias and requantization scale values for the
// current layer from a 32-bit valid/ready parameter stream into on-chip
// flip-flop storage. The postprocessor reads them back through a read port
// indexed by output channel, with a latency of 1 cycle.
//
// Stream order per load: n_chn bias beats, then n_chn scale beats, with
// channel 0 first.
//
// Optional feature macro: PP_PARAM_CHECKSUM_EN
//   When this macro is defined, the module adds an o_checksum output. It holds
//   the 32-bit wrapping sum of every beat accepted during the current load.
//
// Ports
//   clk, rstn        clock (rising edge) and asynchronous active-low reset
//   q_layer          layer index, latched into o_layer on an accepted start
//   i_load_start     one-cycle start pulse; ignored unless the FSM is idle
//   i_num_chn        channel count 0..2^W_CHANNEL, sampled on start
//   s_data/s_vld     parameter stream input
//   s_rdy            loader accepts a beat (registered state decode)
//   o_busy           a load is in progress
//   o_load_done      one-cycle pulse when a load completes
//   o_params_vld     stored parameters are complete for o_layer
//   o_layer          layer index of the last accepted start
//   i_rd_en/i_rd_chn read request and channel
//   o_rd_vld         read data valid (i_rd_en delayed by one cycle)
//   o_bias/o_scale   registered read data
//   o_checksum       (PP_PARAM_CHECKSUM_EN only) sum of accepted beats
module pp_param_loader #(
  parameter int W_CHANNEL = 8,
  parameter int BIAS_DW   = 32,
  parameter int SCALES_DW = 16,
  parameter int S_DW      = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [4:0]           q_layer,
  input  logic                 i_load_start,
  input  logic [W_CHANNEL:0]   i_num_chn,
  input  logic [S_DW-1:0]      s_data,
  input  logic                 s_vld,
  output logic                 s_rdy,
  output logic                 o_busy,
  output logic                 o_load_done,
  output logic                 o_params_vld,
  output logic [4:0]           o_layer,
  input  logic                 i_rd_en,
  input  logic [W_CHANNEL-1:0] i_rd_chn,
  output logic                 o_rd_vld,
  output logic [BIAS_DW-1:0]   o_bias,
  output logic [SCALES_DW-1:0] o_scale
`ifdef PP_PARAM_CHECKSUM_EN
  ,
  output logic [31:0]          o_checksum
`endif
);

  localparam int DEPTH = 1 << W_CHANNEL;
  localparam logic [W_CHANNEL-1:0] CNT_ONE = W_CHANNEL'(1);
  localparam logic [W_CHANNEL:0]   NUM_ONE = (W_CHANNEL + 1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_BIAS  = 2'd1,
    LD_SCALE = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [W_CHANNEL-1:0]   ch_cnt_q, ch_cnt_d;
  logic [W_CHANNEL:0]     n_chn_q, n_chn_d;
  logic [4:0]             layer_q, layer_d;
  logic                   s_rdy_q;
  logic                   done_q;
  logic                   params_vld_q;
  logic                   rd_vld_q;
  logic [BIAS_DW-1:0]     bias_q;
  logic [SCALES_DW-1:0]   scale_q;

  logic                   start_acc;
  logic                   hs;
  logic                   last_beat;
  logic                   bias_we;
  logic                   scale_we;

  // Parameter storage. It is not reset: o_params_vld tells the consumer
  // whether the contents are valid.
  logic [BIAS_DW-1:0]     bias_mem  [DEPTH];
  logic [SCALES_DW-1:0]   scale_mem [DEPTH];

  // s_rdy_q is high exactly in LD_BIAS/LD_SCALE, so it qualifies the handshake.
  assign hs        = s_vld & s_rdy_q;
  assign last_beat = ({1'b0, ch_cnt_q} == (n_chn_q - NUM_ONE));

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    n_chn_d   = n_chn_q;
    layer_d   = layer_q;
    start_acc = 1'b0;
    bias_we   = 1'b0;
    scale_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load_start) begin
          start_acc = 1'b1;
          layer_d   = q_layer;
          n_chn_d   = i_num_chn;
          ch_cnt_d  = '0;
          // An empty load still passes through DONE, so the done pulse fires.
          state_d   = (i_num_chn == '0) ? DONE : LD_BIAS;
        end
      end
      LD_BIAS: begin
        if (hs) begin
          bias_we = 1'b1;
          if (last_beat) begin
            ch_cnt_d = '0;
            state_d  = LD_SCALE;
          end else begin
            ch_cnt_d = ch_cnt_q + CNT_ONE;
          end
        end
      end
      LD_SCALE: begin
        if (hs) begin
          scale_we = 1'b1;
          if (last_beat) begin
            ch_cnt_d = '0;
            state_d  = DONE;
          end else begin
            ch_cnt_d = ch_cnt_q + CNT_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ch_cnt_q     <= '0;
      n_chn_q      <= '0;
      layer_q      <= '0;
      s_rdy_q      <= 1'b0;
      done_q       <= 1'b0;
      params_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      n_chn_q  <= n_chn_d;
      layer_q  <= layer_d;
      // s_rdy is decoded from the next state, so it is a clean flop output.
      s_rdy_q  <= (state_d == LD_BIAS) || (state_d == LD_SCALE);
      // The done pulse and the valid flag both register DONE, so they rise together.
      done_q   <= (state_q == DONE);
      if (start_acc) begin
        params_vld_q <= 1'b0;
      end else if (state_q == DONE) begin
        params_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bias_we) begin
      bias_mem[ch_cnt_q] <= s_data[BIAS_DW-1:0];
    end
    if (scale_we) begin
      scale_mem[ch_cnt_q] <= s_data[SCALES_DW-1:0];
    end
  end

  // Registered read. When a read and a write hit the same entry in one cycle,
  // the read returns the pre-write value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_q <= 1'b0;
      bias_q   <= '0;
      scale_q  <= '0;
    end else begin
      rd_vld_q <= i_rd_en;
      if (i_rd_en) begin
        bias_q  <= bias_mem[i_rd_chn];
        scale_q <= scale_mem[i_rd_chn];
      end
    end
  end

`ifdef PP_PARAM_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (hs) begin
      checksum_q <= checksum_q + s_data[31:0];
    end
  end

  assign o_checksum = checksum_q;
`endif

  assign s_rdy        = s_rdy_q;
  assign o_busy       = (state_q != IDLE);
  assign o_load_done  = done_q;
  assign o_params_vld = params_vld_q;
  assign o_layer      = layer_q;
  assign o_rd_vld     = rd_vld_q;
  assign o_bias       = bias_q;
  assign o_scale      = scale_q;

endmodule

// File: tb/tb_pp_param_loader.sv
// Directed testbench for pp_param_loader: basic load, back-pressure, ignored
// start, empty and full loads, and reset in the middle of a load.
module tb_pp_param_loader;

  logic        clk;
  logic        rstn;
  logic [4:0]  q_layer;
  logic        i_load_start;
  logic [8:0]  i_num_chn;
  logic [31:0] s_data;
  logic        s_vld;
  logic        s_rdy;
  logic        o_busy;
  logic        o_load_done;
  logic        o_params_vld;
  logic [4:0]  o_layer;
  logic        i_rd_en;
  logic [7:0]  i_rd_chn;
  logic        o_rd_vld;
  logic [31:0] o_bias;
  logic [15:0] o_scale;
`ifdef PP_PARAM_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] bias_ref  [256];
  logic [15:0] scale_ref [256];

  int          done_cyc;
  int          nbeats;
  logic [31:0] beat_sum;
  bit          saw_rdy;
  bit          pv_during;

  pp_param_loader dut (
    .clk          (clk),
    .rstn         (rstn),
    .q_layer      (q_layer),
    .i_load_start (i_load_start),
    .i_num_chn    (i_num_chn),
    .s_data       (s_data),
    .s_vld        (s_vld),
    .s_rdy        (s_rdy),
    .o_busy       (o_busy),
    .o_load_done  (o_load_done),
    .o_params_vld (o_params_vld),
    .o_layer      (o_layer),
    .i_rd_en      (i_rd_en),
    .i_rd_chn     (i_rd_chn),
    .o_rd_vld     (o_rd_vld),
    .o_bias       (o_bias),
    .o_scale      (o_scale)
`ifdef PP_PARAM_CHECKSUM_EN
    ,
    .o_checksum   (o_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a load and stream bias_ref/scale_ref. rnd randomises s_vld.
  // inj_cyc > 0 pulses a second start (layer+1, 2 channels) at that cycle.
  // The task returns in the cycle where o_load_done is observed high.
  task automatic run_load(input int n, input logic [4:0] layer, input bit rnd,
                          input int inj_cyc, output int dcyc, output int beats,
                          output logic [31:0] sum, output bit rdy_seen,
                          output bit pv_seen);
    int idx;
    bit hs;
    idx = 0; dcyc = -1; beats = 0; sum = 0; rdy_seen = 0; pv_seen = 0;
    q_layer = layer; i_num_chn = n[8:0]; i_load_start = 1'b1;
    s_vld = 1'b0; s_data = '0;
    tick();
    i_load_start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (o_load_done) begin
        dcyc = c;
        break;
      end
      rdy_seen = rdy_seen | s_rdy;
      pv_seen  = pv_seen | o_params_vld;
      s_vld = (idx < 2 * n) && (!rnd || ($urandom_range(0, 1) == 1));
      if (idx < n)          s_data = bias_ref[idx];
      else if (idx < 2 * n) s_data = {(rnd ? 16'hA5A5 : 16'h0000), scale_ref[idx - n]};
      else                  s_data = '0;
      if (c == inj_cyc) begin
        i_load_start = 1'b1; q_layer = layer + 5'd1; i_num_chn = 9'd2;
      end
      hs = s_vld && s_rdy;
      if (hs) sum = sum + s_data;
      tick();
      i_load_start = 1'b0; q_layer = layer; i_num_chn = n[8:0];
      if (hs) begin
        idx++;
        beats++;
      end
    end
    s_vld = 1'b0;
    $display("[TB] load n=%0d layer=%0d done_cycle=%0d beats=%0d", n, layer, dcyc, beats);
  endtask

  // Back-to-back reads of channels first..first+count-1.
  task automatic read_burst(input int first, input int count, input string tag);
    for (int k = 0; k < count; k++) begin
      i_rd_en = 1'b1;
      i_rd_chn = 8'(first + k);
      tick();
      check($sformatf("%s_vld%0d", tag, first + k), 32'(o_rd_vld), 32'd1);
      check($sformatf("%s_bias%0d", tag, first + k), o_bias, bias_ref[first + k]);
      check($sformatf("%s_scale%0d", tag, first + k), 32'(o_scale), 32'(scale_ref[first + k]));
      $display("[TB] read ch=%0d bias=%0h scale=%0h", first + k, o_bias, o_scale);
    end
    i_rd_en = 1'b0;
    tick();
    check({tag, "_vld_off"}, 32'(o_rd_vld), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; q_layer = '0; i_load_start = 1'b0; i_num_chn = '0;
    s_data = '0; s_vld = 1'b0; i_rd_en = 1'b0; i_rd_chn = '0;

    // Reset state
    tick();
    check("rst_s_rdy", 32'(s_rdy), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_load_done), 32'd0);
    check("rst_pvld", 32'(o_params_vld), 32'd0);
    check("rst_layer", 32'(o_layer), 32'd0);
    check("rst_rd_vld", 32'(o_rd_vld), 32'd0);
    check("rst_bias", o_bias, 32'd0);
    check("rst_scale", 32'(o_scale), 32'd0);
    rstn = 1'b1;
    tick();
    tick();

    // Basic load
    bias_ref[0] = 32'd10; bias_ref[1] = 32'hFFFF_FFFB; bias_ref[2] = 32'h7FFF_FFFF; bias_ref[3] = 32'd1;
    scale_ref[0] = 16'h1234; scale_ref[1] = 16'd2; scale_ref[2] = 16'd3; scale_ref[3] = 16'hABCD;
    run_load(4, 5'd3, 1'b0, 0, done_cyc, nbeats, beat_sum, saw_rdy, pv_during);
    check("basic_done_cyc", 32'(done_cyc), 32'd10);
    check("basic_beats", 32'(nbeats), 32'd8);
    check("basic_layer", 32'(o_layer), 32'd3);
    check("basic_pvld", 32'(o_params_vld), 32'd1);
    check("basic_rdy_seen", 32'(saw_rdy), 32'd1);
    check("basic_rdy_done", 32'(s_rdy), 32'd0);
`ifdef PP_PARAM_CHECKSUM_EN
    check("basic_checksum", o_checksum, 32'h8000_BE0B);
`endif
    tick();
    check("basic_done_pulse", 32'(o_load_done), 32'd0);
    check("basic_pvld_hold", 32'(o_params_vld), 32'd1);
    read_burst(0, 4, "basic");

    // Back-pressure
    for (int i = 0; i < 8; i++) begin
      bias_ref[i] = $urandom;
      scale_ref[i] = 16'($urandom);
    end
    run_load(8, 5'd7, 1'b1, 0, done_cyc, nbeats, beat_sum, saw_rdy, pv_during);
    check("bp_beats", 32'(nbeats), 32'd16);
    check("bp_min_len", 32'(done_cyc >= 18), 32'd1);
    check("bp_pvld_cleared", 32'(pv_during), 32'd0);
    check("bp_layer", 32'(o_layer), 32'd7);
`ifdef PP_PARAM_CHECKSUM_EN
    check("bp_checksum", o_checksum, beat_sum);
`endif
    tick();
    read_burst(0, 8, "bp");

    // Ignored start
    for (int i = 0; i < 5; i++) begin
      bias_ref[i] = 32'h1000_0000 + 32'(i * 17);
      scale_ref[i] = 16'h0100 + 16'(i);
    end
    run_load(5, 5'd12, 1'b0, 2, done_cyc, nbeats, beat_sum, saw_rdy, pv_during);
    check("ign_beats", 32'(nbeats), 32'd10);
    check("ign_done_cyc", 32'(done_cyc), 32'd12);
    check("ign_layer", 32'(o_layer), 32'd12);
    tick();
    read_burst(0, 5, "ign");

    // Empty load
    run_load(0, 5'd4, 1'b0, 0, done_cyc, nbeats, beat_sum, saw_rdy, pv_during);
    check("zero_done_cyc", 32'(done_cyc), 32'd2);
    check("zero_rdy_seen", 32'(saw_rdy), 32'd0);
    check("zero_beats", 32'(nbeats), 32'd0);
    check("zero_layer", 32'(o_layer), 32'd4);
    check("zero_pvld", 32'(o_params_vld), 32'd1);
`ifdef PP_PARAM_CHECKSUM_EN
    check("zero_checksum", o_checksum, 32'd0);
`endif
    tick();

    // Full load
    for (int i = 0; i < 256; i++) begin
      bias_ref[i] = $urandom;
      scale_ref[i] = 16'($urandom);
    end
    run_load(256, 5'd31, 1'b0, 0, done_cyc, nbeats, beat_sum, saw_rdy, pv_during);
    check("full_done_cyc", 32'(done_cyc), 32'd514);
    check("full_beats", 32'(nbeats), 32'd512);
    check("full_layer", 32'(o_layer), 32'd31);
    tick();
    read_burst(254, 2, "full_hi");
    read_burst(0, 2, "full_lo");

    // Reset mid-load after 3 bias beats
    q_layer = 5'd9; i_num_chn = 9'd4; i_load_start = 1'b1; s_vld = 1'b0;
    tick();
    i_load_start = 1'b0; s_vld = 1'b1; s_data = 32'h1111_1111;
    tick();
    s_data = 32'h2222_2222;
    tick();
    s_data = 32'h3333_3333; i_rd_en = 1'b1; i_rd_chn = 8'd0;
    tick();
    i_rd_en = 1'b0;
    check("mid_pre_rd_vld", 32'(o_rd_vld), 32'd1);
    check("mid_pre_bias", o_bias, 32'h1111_1111);
    check("mid_pre_busy", 32'(o_busy), 32'd1);
    check("mid_pre_rdy", 32'(s_rdy), 32'd1);
    check("mid_pre_layer", 32'(o_layer), 32'd9);
    #2;
    rstn = 1'b0;
    #1;
    $display("[TB] reset asserted mid-load");
    check("mid_rst_rdy", 32'(s_rdy), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_done", 32'(o_load_done), 32'd0);
    check("mid_rst_pvld", 32'(o_params_vld), 32'd0);
    check("mid_rst_rd_vld", 32'(o_rd_vld), 32'd0);
    check("mid_rst_layer", 32'(o_layer), 32'd0);
    check("mid_rst_bias", o_bias, 32'd0);
    check("mid_rst_scale", 32'(o_scale), 32'd0);
`ifdef PP_PARAM_CHECKSUM_EN
    check("mid_rst_checksum", o_checksum, 32'd0);
`endif
    s_vld = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    tick();
    check("mid_post_pvld", 32'(o_params_vld), 32'd0);
    check("mid_post_busy", 32'(o_busy), 32'd0);
    check("mid_post_rdy", 32'(s_rdy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
